exhaustive_eval_ctrl: RTL and testbench
=======================================

# exhaustive_eval_ctrl

Sequencer that exhaustively sweeps all 2^NI input vectors through a reference benchmark netlist and an evolved candidate netlist in parallel, both combinational and both driven by the same `vec` bus. It counts mismatching output bits (Hamming distance over the full truth table), records which outputs ever failed and the first failing vector, and supports early termination once the error budget is exceeded. It sits between the CGP fitness loop and the circuit-under-evaluation pair and turns a combinational benchmark into a start/done fitness engine.

## Interface
- `NI`, 8, primary-input count of the evaluated circuits.
- `NO`, 7, primary-output count of the evaluated circuits.
- `ERRW` is a localparam, not a parameter: $clog2(NO*2^NI + 1), which is 11 at the defaults.

Ports:
- `clk`  in  1  sole clock; everything is sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin an evaluation; honoured only in IDLE.
- `abort`  in  1  cancel an evaluation in flight.
- `max_err`  in  ERRW  error budget; the sweep terminates when `err_count` > `max_err`.
- `vec`  out  NI  input vector driven to both circuits.
- `ref_po`  in  NO  reference circuit outputs for the current `vec`.
- `cand_po`  in  NO  candidate circuit outputs for the current `vec`.
- `busy`  out  1  high while the state is SWEEP or DRAIN.
- `done`  out  1  one-cycle pulse; the results below are final while it is high.
- `err_count`  out  ERRW  accumulated mismatching output bits.
- `exceeded`  out  1  the sweep stopped early on the budget.
- `fail_mask`  out  NO  OR over all evaluated vectors of `ref_po ^ cand_po`.
- `first_fail_vec`  out  NI  first vector that produced a nonzero mismatch.
- `first_fail_valid`  out  1  `first_fail_vec` holds a valid vector.

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE
  - `start` && !`abort` → SWEEP.
  - On that same edge: clear `err_count`, `exceeded`, `fail_mask`, `first_fail_valid`; set `vec` = 0.
- SWEEP
  - At each edge, register `diff_q` = `ref_po ^ cand_po` and `vec_q` = `vec`.
  - `vec` increments by 1.
  - When `vec` == 2^NI−1, go to DRAIN; `vec` wraps to 0 and holds there.
- Accumulate stage, active whenever `diff_q` is valid:
  - `err_count` += popcount(`diff_q`).
  - `fail_mask` |= `diff_q`.
  - If `diff_q` != 0 and !`first_fail_valid`: latch `first_fail_vec` = `vec_q` and set `first_fail_valid`.
- DRAIN: accumulate the last vector, then go to DONE.
- Early termination: if the sum produced on an edge is > `max_err`:
  - Set `exceeded` and go to DONE.
  - The `diff_q` captured on that same edge is discarded.
  - `max_err` = 2^ERRW−1 disables early termination.
- DONE: `done` = 1 for one cycle, then IDLE. Results hold until the next accepted `start` or `rst`.
- `abort` in SWEEP or DRAIN:
  - Next state IDLE; no `done` pulse.
  - Partial results hold; `exceeded` is not set.
  - `abort` wins over the budget check on the same edge.
- `start` outside IDLE, and `abort` in IDLE or DONE, are ignored.
- `max_err` is sampled every accumulate edge; it must be held stable during a sweep.
- Widths: the adder is ERRW bits, so it cannot overflow (maximum NO·2^NI < 2^ERRW).

## Timing
- Reset values: state IDLE; `vec` = 0, `busy` = 0, `done` = 0, `err_count` = 0, `exceeded` = 0, `fail_mask` = 0, `first_fail_vec` = 0, `first_fail_valid` = 0.
- Reset applies on the edge where `rst` is high, including mid-sweep; the in-flight `diff_q` is discarded.
- Sweep timeline, with S = cycle in which `start` is accepted:
  - vector k is driven in cycle S+1+k;
  - it is captured at the end of S+1+k and accumulated at the end of S+2+k.
- `busy` is high in S+1 … S+2^NI+1.
- `done` is high in S+2^NI+2 (S+258 at the defaults). Total latency from `start` is 2^NI+2 cycles.
- Early stop: if vector k's accumulation exceeds the budget, `done` is high in S+3+k.
- `ref_po` and `cand_po` must settle combinationally within one cycle of `vec`.
- Back-to-back evaluations: `start` is accepted in the cycle after DONE, so the minimum period is 2^NI+3 cycles.

## Test plan
- `cand_po` tied to `ref_po`, `max_err` = 2047: `done` at S+258; `err_count` = 0, `fail_mask` = 0, `first_fail_valid` = 0, `exceeded` = 0; `vec` walks 0..255 in cycles S+1..S+256.
- `cand_po` = `ref_po` with bit 0 inverted: `err_count` = 256, `fail_mask` = 7'b0000001, `first_fail_vec` = 8'h00, `first_fail_valid` = 1.
- `cand_po` = `ref_po` ^ (7'b0001000 when `vec` == 8'hA5): `err_count` = 1, `first_fail_vec` = 8'hA5, `fail_mask` = 7'b0001000, `done` at S+258.
- All 7 outputs inverted, `max_err` = 100: `err_count` = 105, `exceeded` = 1, `done` in S+17, `busy` low from S+17.
- `abort` in S+50: `busy` low from S+51, no `done` pulse, partial results held. `start` in S+52 clears the results and gives a full correct run, with `done` at S+52+258.
- `rst` in S+100: all outputs at reset values in S+101. `start` pulsed during an active sweep is ignored, and `done` is still at S+258.

Source files
------------

// File: rtl/exhaustive_eval_ctrl.sv
// exhaustive_eval_ctrl: sweeps all 2^NI vectors through a reference and a
// candidate netlist, accumulating Hamming distance and first-failure info.
module exhaustive_eval_ctrl #(
  parameter int NI = 8,
  parameter int NO = 7,
  localparam int ERRW = $clog2(NO * (1 << NI) + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [ERRW-1:0] max_err,
  output logic [NI-1:0]   vec,
  input  logic [NO-1:0]   ref_po,
  input  logic [NO-1:0]   cand_po,
  output logic            busy,
  output logic            done,
  output logic [ERRW-1:0] err_count,
  output logic            exceeded,
  output logic [NO-1:0]   fail_mask,
  output logic [NI-1:0]   first_fail_vec,
  output logic            first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [NO-1:0]   diff_q;
  logic [NI-1:0]   vec_q;
  logic            diff_vld;
  logic [ERRW-1:0] sum;
  logic            over;
  logic            go;
  logic            sweeping;

  function automatic logic [ERRW-1:0] popcnt(input logic [NO-1:0] d);
    logic [ERRW-1:0] n;
    n = '0;
    for (int i = 0; i < NO; i++) begin
      n = n + ERRW'(d[i]);
    end
    return n;
  endfunction

  assign go       = (state_q == IDLE) && start && !abort;
  assign sweeping = (state_q == SWEEP);
  assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  // Next state, running sum and budget comparison
  always_comb begin
    state_d = state_q;
    sum     = err_count + popcnt(diff_q);
    over    = diff_vld && (sum > max_err);
    unique case (state_q)
      IDLE: begin
        if (go) state_d = SWEEP;
      end
      SWEEP: begin
        if (abort)     state_d = IDLE;
        else if (over) state_d = DONE;
        else if (&vec) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
        else       state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Vector counter, capture stage and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      vec              <= '0;
      vec_q            <= '0;
      diff_q           <= '0;
      diff_vld         <= 1'b0;
      err_count        <= '0;
      exceeded         <= 1'b0;
      fail_mask        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      diff_vld <= sweeping && !abort && !over;
      if (go) begin
        vec              <= '0;
        err_count        <= '0;
        exceeded         <= 1'b0;
        fail_mask        <= '0;
        first_fail_valid <= 1'b0;
      end
      if (sweeping) begin
        diff_q <= ref_po ^ cand_po;
        vec_q  <= vec;
        if (abort || over) vec <= '0;
        else               vec <= vec + NI'(1);
      end
      if (diff_vld) begin
        err_count <= sum;
        fail_mask <= fail_mask | diff_q;
        if ((|diff_q) && !first_fail_valid) begin
          first_fail_vec   <= vec_q;
          first_fail_valid <= 1'b1;
        end
        if (over && !abort) exceeded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exhaustive_eval_ctrl.sv
// tb_exhaustive_eval_ctrl: randomized and directed sweeps checked against
// a truth-table level model of the Hamming-distance fitness result.
module tb_exhaustive_eval_ctrl;

  localparam int NV   = 256;
  localparam int LOOP = 330;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] max_err = 11'd2047;
  logic [7:0]  vec;
  logic [6:0]  ref_po;
  logic [6:0]  cand_po;
  logic        busy;
  logic        done;
  logic [10:0] err_count;
  logic        exceeded;
  logic [6:0]  fail_mask;
  logic [7:0]  first_fail_vec;
  logic        first_fail_valid;

  logic [6:0]  tab [0:NV-1];
  int          ec  [0:LOOP];
  logic [6:0]  fm  [0:LOOP];
  logic        bz  [0:LOOP];
  int          n_chk = 0;
  int          n_pass = 0;
  int          done_at;
  int          ndone;
  int          walk_bad;

  always #5 clk = ~clk;

  assign ref_po  = vec[6:0] ^ {vec[0], vec[7:2]};
  assign cand_po = ref_po ^ tab[vec];

  exhaustive_eval_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .max_err          (max_err),
    .vec              (vec),
    .ref_po           (ref_po),
    .cand_po          (cand_po),
    .busy             (busy),
    .done             (done),
    .err_count        (err_count),
    .exceeded         (exceeded),
    .fail_mask        (fail_mask),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Fold the truth table of mismatches in vector order
  task automatic model(input int maxe, input int nvec,
                       output int e, output int m, output int fv,
                       output int ff, output int ex, output int dn);
    e = 0; m = 0; fv = 0; ff = 0; ex = 0; dn = NV + 2;
    for (int k = 0; k < nvec; k++) begin
      e += $countones(tab[k]);
      m |= int'(tab[k]);
      if (tab[k] != 0 && fv == 0) begin
        fv = 1;
        ff = k;
      end
      if (e > maxe) begin
        ex = 1;
        dn = 3 + k;
        break;
      end
    end
  endtask

  task automatic expect_final(input string tag, input int nvec);
    int e, m, fv, ff, ex, dn;
    model(int'(max_err), nvec, e, m, fv, ff, ex, dn);
    check({tag, ".err"}, int'(err_count), e);
    check({tag, ".mask"}, int'(fail_mask), m);
    check({tag, ".ffv"}, int'(first_fail_valid), fv);
    if (fv != 0) check({tag, ".ffvec"}, int'(first_fail_vec), ff);
    check({tag, ".exc"}, int'(exceeded), ex);
    check({tag, ".done_at"}, done_at, dn);
    check({tag, ".ndone"}, ndone, 1);
  endtask

  task automatic sweep(input int ab_at, input int rst_at, input int st_at);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_at = -1;
    ndone = 0;
    walk_bad = 0;
    for (int i = 1; i <= LOOP; i++) begin
      ec[i] = int'(err_count);
      fm[i] = fail_mask;
      bz[i] = busy;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = i;
      end
      if (i <= NV && vec !== 8'(i - 1)) walk_bad++;
      abort = (i == ab_at);
      rst   = (i == rst_at);
      start = (i == st_at);
      @(negedge clk);
    end
    abort = 1'b0;
    rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < NV; k++) begin
      unique case (mode)
        0: tab[k] = 7'd0;
        1: tab[k] = 7'b0000001;
        2: tab[k] = (k == 8'hA5) ? 7'b0001000 : 7'd0;
        3: tab[k] = 7'h7F;
        default: tab[k] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : 7'd0;
      endcase
    end
  endtask

  initial begin
    int e, m, fv, ff, ex, dn;
    fill(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.vec", int'(vec), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.err", int'(err_count), 0);
    check("rst.mask", int'(fail_mask), 0);
    check("rst.ffv", int'(first_fail_valid), 0);

    max_err = 11'd2047;
    sweep(0, 0, 0);
    expect_final("tie", NV);
    check("tie.walk", walk_bad, 0);
    check("tie.busy1", int'(bz[1]), 1);
    check("tie.busy257", int'(bz[257]), 1);
    check("tie.busy258", int'(bz[258]), 0);

    fill(1);
    sweep(0, 0, 0);
    expect_final("bit0", NV);

    fill(2);
    sweep(0, 0, 0);
    expect_final("a5", NV);

    fill(3);
    max_err = 11'd100;
    sweep(0, 0, 0);
    expect_final("inv", NV);
    check("inv.busy16", int'(bz[16]), 1);
    check("inv.busy17", int'(bz[17]), 0);

    for (int r = 0; r < 4; r++) begin
      fill(4);
      max_err = (r == 0) ? 11'd2047 : 11'($urandom_range(0, 120));
      sweep(0, 0, 0);
      expect_final($sformatf("rnd%0d", r), NV);
    end

    fill(4);
    max_err = 11'd2047;
    sweep(50, 0, 52);
    model(2047, 49, e, m, fv, ff, ex, dn);
    check("abt.busy50", int'(bz[50]), 1);
    check("abt.busy51", int'(bz[51]), 0);
    check("abt.err51", ec[51], e);
    check("abt.mask51", int'(fm[51]), m);
    check("abt.err52", ec[52], e);
    done_at = done_at - 52;
    expect_final("abt.rerun", NV);

    fill(3);
    sweep(0, 100, 0);
    check("rst2.busy101", int'(bz[101]), 0);
    check("rst2.err101", ec[101], 0);
    check("rst2.mask101", int'(fm[101]), 0);
    check("rst2.ndone", ndone, 0);
    check("rst2.vec", int'(vec), 0);
    check("rst2.ffv", int'(first_fail_valid), 0);
    check("rst2.ffvec", int'(first_fail_vec), 0);
    check("rst2.exc", int'(exceeded), 0);

    fill(2);
    sweep(0, 0, 30);
    expect_final("ign", NV);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
